// File: rtl/steer_pkg.sv
// ---------------------------------------------------------------------------
// steer_pkg
// Shared constants for the steering datapath: load-cell sample width,
// rider weight threshold with its hysteresis, and the settle-timer terminal
// counts for hardware (1.3 s at 50 MHz) and fast simulation.
// ---------------------------------------------------------------------------
package steer_pkg;

    localparam int LC_W = 12;                       // load-cell sample width
    localparam int ACC_W = LC_W + 2;                // 4-sample accumulator width
    localparam int SUM_W = LC_W + 1;                // avg_l + avg_r width
    localparam int TMR_W = 26;                      // settle timer width

    localparam logic [LC_W-1:0] MIN_RIDER_WEIGHT = 12'h200;
    localparam logic [LC_W-1:0] HYSTERESIS       = 12'h040;

    localparam logic [SUM_W-1:0] SUM_GT_THRESH =
        {1'b0, MIN_RIDER_WEIGHT} + {1'b0, HYSTERESIS};   // 0x240
    localparam logic [SUM_W-1:0] SUM_LT_THRESH =
        {1'b0, MIN_RIDER_WEIGHT} - {1'b0, HYSTERESIS};   // 0x1C0

    localparam logic [TMR_W-1:0] TMR_TERM_FULL = 26'd64_999_999;
    localparam logic [TMR_W-1:0] TMR_TERM_SIM  = 26'd32_767;

endpackage

// File: rtl/ld_cell_avg.sv
// ---------------------------------------------------------------------------
// ld_cell_avg
// 4-sample running average of one load-cell channel. A 4-deep history and a
// running accumulator update only on vld; missing history entries start at
// zero, so the average ramps up over the first four samples.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   vld    in   sample strobe
//   ld     in   [LC_W-1:0] raw sample
//   avg    out  [LC_W-1:0] average of the last four samples (floor)
// ---------------------------------------------------------------------------
module ld_cell_avg
    import steer_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            vld,
    input  logic [LC_W-1:0] ld,
    output logic [LC_W-1:0] avg
);

    // tap[0] is the incoming sample, tap[4] the oldest stored sample
    logic [LC_W-1:0]  tap [0:4];
    logic [ACC_W-1:0] acc_reg;

    assign tap[0] = ld;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_hist
            logic [LC_W-1:0] slot_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_reg <= '0;
                end else if (vld) begin
                    slot_reg <= tap[gi];
                end
            end

            assign tap[gi+1] = slot_reg;
        end
    endgenerate

    // The accumulator always equals the sum of the four history slots, so it
    // never exceeds 4 * 0xFFF and cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
        end else if (vld) begin
            acc_reg <= acc_reg + {2'b00, ld} - {2'b00, tap[4]};
        end
    end

    assign avg = acc_reg[ACC_W-1:2];

endmodule

// File: rtl/rider_detect.sv
// ---------------------------------------------------------------------------
// rider_detect
// Rider presence/balance datapath for the steering-enable state machine.
// Averages both load cells, compares sum and imbalance against thresholds,
// registers four flags, and runs the saturating 1.3 s settle timer.
//
// Ports:
//   clk            in   50 MHz system clock
//   rst_n          in   asynchronous active-low reset
//   lft_ld         in   [11:0] left load-cell sample
//   rght_ld        in   [11:0] right load-cell sample
//   vld            in   sample strobe for lft_ld/rght_ld
//   clr_tmr        in   synchronous settle-timer clear
//   tmr_full       out  timer at terminal count
//   sum_gt_min     out  sum > MIN_RIDER_WEIGHT + HYSTERESIS
//   sum_lt_min     out  sum < MIN_RIDER_WEIGHT - HYSTERESIS
//   diff_gt_1_4    out  |avg_l - avg_r| > sum/4
//   diff_gt_15_16  out  |avg_l - avg_r| > 15*sum/16
// ---------------------------------------------------------------------------
module rider_detect
    import steer_pkg::*;
#(
    parameter bit FAST_SIM = 1'b0
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [LC_W-1:0] lft_ld,
    input  logic [LC_W-1:0] rght_ld,
    input  logic            vld,
    input  logic            clr_tmr,
    output logic            tmr_full,
    output logic            sum_gt_min,
    output logic            sum_lt_min,
    output logic            diff_gt_1_4,
    output logic            diff_gt_15_16
);

    localparam logic [TMR_W-1:0] TMR_TERM = FAST_SIM ? TMR_TERM_SIM : TMR_TERM_FULL;

    logic [LC_W-1:0]  avg_l;
    logic [LC_W-1:0]  avg_r;
    logic [SUM_W-1:0] sum;
    logic [LC_W-1:0]  diff;
    logic [SUM_W-1:0] quarter;
    logic [16:0]      sum_x15;
    logic [SUM_W-1:0] frac_15_16;

    logic sum_gt_next, sum_lt_next, diff_14_next, diff_1516_next;
    logic sum_gt_reg,  sum_lt_reg,  diff_14_reg,  diff_1516_reg;
    logic [TMR_W-1:0] cnt_reg;

    ld_cell_avg u_avg_l (
        .clk   (clk),
        .rst_n (rst_n),
        .vld   (vld),
        .ld    (lft_ld),
        .avg   (avg_l)
    );

    ld_cell_avg u_avg_r (
        .clk   (clk),
        .rst_n (rst_n),
        .vld   (vld),
        .ld    (rght_ld),
        .avg   (avg_r)
    );

    // ---------------- threshold compares (stage 2 inputs) -----------------
    always_comb begin
        sum        = {1'b0, avg_l} + {1'b0, avg_r};
        diff       = (avg_l >= avg_r) ? (avg_l - avg_r) : (avg_r - avg_l);
        quarter    = {2'b00, sum[SUM_W-1:2]};
        // 15*sum needs 17 bits; after >>4 it fits back into 13
        sum_x15    = {4'd0, sum} * 17'd15;
        frac_15_16 = sum_x15[16:4];

        sum_gt_next    = (sum > SUM_GT_THRESH);
        sum_lt_next    = (sum < SUM_LT_THRESH);
        diff_14_next   = ({1'b0, diff} > quarter);
        diff_1516_next = ({1'b0, diff} > frac_15_16);
    end

    // Flags register every cycle so they stay steady between samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_gt_reg    <= 1'b0;
            sum_lt_reg    <= 1'b0;
            diff_14_reg   <= 1'b0;
            diff_1516_reg <= 1'b0;
        end else begin
            sum_gt_reg    <= sum_gt_next;
            sum_lt_reg    <= sum_lt_next;
            diff_14_reg   <= diff_14_next;
            diff_1516_reg <= diff_1516_next;
        end
    end

    assign sum_gt_min    = sum_gt_reg;
    assign sum_lt_min    = sum_lt_reg;
    assign diff_gt_1_4   = diff_14_reg;
    assign diff_gt_15_16 = diff_1516_reg;

    // ---------------- settle timer: clear wins, then saturate -------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr_tmr) begin
            cnt_reg <= '0;
        end else if (cnt_reg != TMR_TERM) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tmr_full = (cnt_reg == TMR_TERM);

endmodule

// File: tb/tb_rider_detect.sv
// ---------------------------------------------------------------------------
// tb_rider_detect
// Self-checking bench for rider_detect (FAST_SIM=1). A reference model keeps
// the last four samples per side in plain arrays, derives averages and flags
// with integer arithmetic, and tracks edges since the last timer clear.
// ---------------------------------------------------------------------------
module tb_rider_detect;

    localparam int TERM = 32767;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] lft_ld = '0;
    logic [11:0] rght_ld = '0;
    logic        vld = 1'b0;
    logic        clr_tmr = 1'b0;
    logic        tmr_full, sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16;

    rider_detect #(.FAST_SIM(1'b1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .lft_ld        (lft_ld),
        .rght_ld       (rght_ld),
        .vld           (vld),
        .clr_tmr       (clr_tmr),
        .tmr_full      (tmr_full),
        .sum_gt_min    (sum_gt_min),
        .sum_lt_min    (sum_lt_min),
        .diff_gt_1_4   (diff_gt_1_4),
        .diff_gt_15_16 (diff_gt_15_16)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    int hl [4];
    int hr [4];
    int edges;
    bit e_gt, e_lt, e_14, e_1516;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            hl[i] = 0;
            hr[i] = 0;
        end
        edges  = 0;
        e_gt   = 0;
        e_lt   = 0;
        e_14   = 0;
        e_1516 = 0;
    endtask

    // Flags from the current model averages: avg is the floor of the mean of
    // the last four samples; ratios are tested by cross-multiplication.
    task automatic model_flags();
        int al, ar, s, d;
        al = (hl[0] + hl[1] + hl[2] + hl[3]) / 4;
        ar = (hr[0] + hr[1] + hr[2] + hr[3]) / 4;
        s  = al + ar;
        d  = (al > ar) ? al - ar : ar - al;
        e_gt   = (s > 'h240);
        e_lt   = (s < 'h1C0);
        e_14   = (4 * d > s);
        e_1516 = (16 * d > 15 * s);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".gt"},   32'(sum_gt_min),    32'(e_gt));
        chk({tag, ".lt"},   32'(sum_lt_min),    32'(e_lt));
        chk({tag, ".d14"},  32'(diff_gt_1_4),   32'(e_14));
        chk({tag, ".d1516"},32'(diff_gt_15_16), 32'(e_1516));
        chk({tag, ".tmr"},  32'(tmr_full),      32'(edges >= TERM));
    endtask

    // One clock: drive, take the edge, advance the model, check #1 later.
    task automatic step(input bit v, input int l, input int r, input bit c, input bit quiet);
        lft_ld  = l[11:0];
        rght_ld = r[11:0];
        vld     = v;
        clr_tmr = c;
        @(posedge clk);
        if (rst_n) begin
            model_flags();          // flags register the pre-edge averages
            if (v) begin
                for (int i = 3; i > 0; i--) begin
                    hl[i] = hl[i-1];
                    hr[i] = hr[i-1];
                end
                hl[0] = l & 'hFFF;
                hr[0] = r & 'hFFF;
            end
            if (c) edges = 0;
            else if (edges < TERM) edges++;
        end
        #1;
        check_all("step");
        if (v && !quiet)
            $display("txn l=%03h r=%03h clr=%0d -> gt=%0d lt=%0d d14=%0d d1516=%0d full=%0d",
                     l[11:0], r[11:0], c, sum_gt_min, sum_lt_min, diff_gt_1_4,
                     diff_gt_15_16, tmr_full);
        vld     = 1'b0;
        clr_tmr = 1'b0;
    endtask

    task automatic load4(input int l, input int r);
        for (int i = 0; i < 4; i++) step(1, l, r, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
    endtask

    initial begin
        model_clear();
        #1;
        chk("rst.gt",   32'(sum_gt_min),    0);
        chk("rst.lt",   32'(sum_lt_min),    0);
        chk("rst.d14",  32'(diff_gt_1_4),   0);
        chk("rst.d1516",32'(diff_gt_15_16), 0);
        chk("rst.tmr",  32'(tmr_full),      0);
        repeat (2) @(posedge clk);
        #5 rst_n = 1'b1;

        // presence and balance patterns
        load4('h180, 'h180);
        chk("p180.gt", 32'(sum_gt_min), 1);
        chk("p180.lt", 32'(sum_lt_min), 0);
        chk("p180.d14", 32'(diff_gt_1_4), 0);
        load4('h300, 'h000);
        chk("p300.d1516", 32'(diff_gt_15_16), 1);
        chk("p300.d14", 32'(diff_gt_1_4), 1);
        load4('h200, 'h100);
        chk("p21.d14", 32'(diff_gt_1_4), 1);
        chk("p21.d1516", 32'(diff_gt_15_16), 0);
        load4('h0E0, 'h0E0);
        chk("band.gt", 32'(sum_gt_min), 0);
        chk("band.lt", 32'(sum_lt_min), 0);
        load4('h0DF, 'h0E0);
        chk("below.lt", 32'(sum_lt_min), 1);

        // latency: one new sample from a steady 0x180 state moves sum to 0x240
        load4('h180, 'h180);
        step(1, 'h000, 'h000, 0, 0);
        chk("lat.edge1", 32'(sum_gt_min), 1);
        step(0, 0, 0, 0, 1);
        chk("lat.edge2", 32'(sum_gt_min), 0);

        // randomized traffic, biased toward the hysteresis band
        for (int n = 0; n < 300; n++) begin
            int l, r;
            if ($urandom_range(0, 1) == 1) begin
                l = int'($urandom_range(0, 'hFFF));
                r = int'($urandom_range(0, 'hFFF));
            end else begin
                l = int'($urandom_range('hC0, 'h140));
                r = int'($urandom_range('hC0, 'h140));
            end
            step(bit'($urandom_range(0, 1)), l, r, ($urandom_range(0, 19) == 0), 0);
        end

        // timer: rise after TERM edges, then saturate
        step(0, 0, 0, 1, 1);
        for (int i = 0; i < TERM - 1; i++) step(0, 0, 0, 0, 1);
        chk("tmr.early", 32'(tmr_full), 0);
        step(0, 0, 0, 0, 1);
        chk("tmr.rise", 32'(tmr_full), 1);
        for (int i = 0; i < 1000; i++) step(0, 0, 0, 0, 1);
        chk("tmr.sat", 32'(tmr_full), 1);
        step(0, 0, 0, 1, 1);
        chk("tmr.clr_drop", 32'(tmr_full), 0);

        // clear at count 100 restarts from zero
        for (int i = 0; i < 99; i++) step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1);
        for (int i = 0; i < TERM - 1; i++) step(0, 0, 0, 0, 1);
        chk("tmr.restart_early", 32'(tmr_full), 0);
        step(0, 0, 0, 0, 1);
        chk("tmr.restart_rise", 32'(tmr_full), 1);

        // mid-stream asynchronous reset with timer full and flags set
        load4('h180, 'h180);
        chk("prerst.gt", 32'(sum_gt_min), 1);
        #5 rst_n = 1'b0;
        #1;
        model_clear();
        chk("arst.gt",   32'(sum_gt_min),    0);
        chk("arst.tmr",  32'(tmr_full),      0);
        chk("arst.d14",  32'(diff_gt_1_4),   0);
        step(1, 'h7FF, 'h100, 0, 0);
        step(1, 'h7FF, 'h100, 0, 0);
        #4 rst_n = 1'b1;
        step(1, 'h400, 'h400, 0, 0);
        chk("ramp.first_lt", 32'(sum_lt_min), 1);
        step(1, 'h400, 'h400, 0, 0);
        chk("ramp.band_lt", 32'(sum_lt_min), 0);
        step(0, 0, 0, 0, 1);
        chk("ramp.gt", 32'(sum_gt_min), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
